// File: rtl/core_mem_pkg.sv
// Shared memory-subsystem definitions.
// Contents: dmem responder FSM state encoding, the bus field widths (given as
// MSB indices) and the width of the wait-state counter.
package core_mem_pkg;

  localparam int unsigned MEM_ADDR_R = 63;
  localparam int unsigned MEM_DATA_R = 63;
  localparam int unsigned MEM_STRB_R = 7;

  // Wait-state counter width (covers WAIT_CYCLES 0..7).
  localparam int unsigned DMEM_CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_rsp_state_t;

endpackage

// File: rtl/core_dmem_responder_if.sv
// Core data-memory request/response bus.
// master (core side): drives dmem_req, dmem_addr, dmem_wen, dmem_strb and
// dmem_wdata, and receives dmem_gnt, dmem_err and dmem_rdata.
// slave (memory side): the mirror image of master.
interface core_dmem_responder_if;
  import core_mem_pkg::*;

  logic                  dmem_req;
  logic [MEM_ADDR_R:0]   dmem_addr;
  logic                  dmem_wen;
  logic [MEM_STRB_R:0]   dmem_strb;
  logic [MEM_DATA_R:0]   dmem_wdata;
  logic                  dmem_gnt;
  logic                  dmem_err;
  logic [MEM_DATA_R:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    input  dmem_gnt, dmem_err, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_addr, dmem_wen, dmem_strb, dmem_wdata,
    output dmem_gnt, dmem_err, dmem_rdata
  );

endinterface

// File: rtl/core_sram_1rw.sv
// Single-port SRAM with a synchronous read and per-byte write enables.
// Ports:
//   g_clk - clock
//   en    - access enable
//   we    - write when set, read otherwise
//   be    - byte enables
//   idx   - word index
//   wdata - write data
//   rdata - read data; updates only on an enabled read
// The array has no reset.
module core_sram_1rw #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned NB    = DATA_W / 8
) (
  input  logic              g_clk,
  input  logic              en,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write, or a registered read of the whole word.
  always_ff @(posedge g_clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < int'(NB); i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/core_dmem_responder.sv
// Data-memory responder for the core's dmem port.
// It inserts WAIT_CYCLES wait states before the grant, decodes the address
// window starting at BASE_ADDR and accesses core_sram_1rw. The response
// (err, rdata) appears one cycle after the handshake.
// Ports:
//   g_clk   - clock
//   g_reset - asynchronous, active-high reset
//   dmem    - request/response bus (slave side)
module core_dmem_responder
  import core_mem_pkg::*;
#(
  parameter logic [MEM_ADDR_R:0] BASE_ADDR   = 64'h0000_0000_2000_0000,
  parameter int unsigned         DEPTH_WORDS = 1024,
  parameter int unsigned         WAIT_CYCLES = 0
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  core_dmem_responder_if.slave   dmem
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [MEM_ADDR_R:0] MEM_BYTES = 64'(DEPTH_WORDS) << 3;
  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? DMEM_CNT_W'(WAIT_CYCLES - 1) : '0;

  dmem_rsp_state_t       state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  gnt_c;
  logic                  hs;
  logic [MEM_ADDR_R:0]   offs;
  logic                  in_range;
  logic                  err_q;
  logic                  rd_ok_q;
  logic [MEM_DATA_R:0]   sram_rdata;

  // Address window decode; low three address bits select nothing here.
  assign offs     = dmem.dmem_addr - BASE_ADDR;
  assign in_range = (dmem.dmem_addr >= BASE_ADDR) && (offs < MEM_BYTES);
  assign hs       = dmem.dmem_req && gnt_c;

  // State and wait counter.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and grant. Reset forces the grant low, which also blocks any
  // array write on an edge where reset is asserted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (WAIT_CYCLES == 0) begin
          gnt_c = dmem.dmem_req;
        end else if (dmem.dmem_req) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (!dmem.dmem_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          gnt_c   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - DMEM_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (g_reset) gnt_c = 1'b0;
  end

  // Response flags. They hold until the next handshake.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else if (hs) begin
      err_q   <= !in_range;
      rd_ok_q <= in_range && !dmem.dmem_wen;
    end
  end

  core_sram_1rw #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (MEM_DATA_R + 1)
  ) u_sram (
    .g_clk (g_clk),
    .en    (hs && in_range),
    .we    (dmem.dmem_wen),
    .be    (dmem.dmem_strb),
    .idx   (offs[IDX_W+2:3]),
    .wdata (dmem.dmem_wdata),
    .rdata (sram_rdata)
  );

  // The SRAM output register holds between reads, so masking it with the
  // read flag gives a held response that is zero for writes and errors.
  assign dmem.dmem_gnt   = gnt_c;
  assign dmem.dmem_err   = err_q;
  assign dmem.dmem_rdata = rd_ok_q ? sram_rdata : '0;

endmodule
